alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5, width of Operation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, SrcA/SrcB/Operation valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have ports SrcA and SrcB, input, DATA_WIDTH, operands.
REQ-008 SHALL have port Operation, input, OPCODE_LENGTH, opcode from alu_pkg.
REQ-009 SHALL have port out_valid, output, 1, ALUResult valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-011 SHALL have port ALUResult, output, DATA_WIDTH, registered result.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL accept a request on the clk edge where in_valid && in_ready; operands and opcode are captured, not sampled later.
REQ-014 SHALL drive in_ready = 1 only in state IDLE.
REQ-015 SHALL implement FSM IDLE -> {DONE | MUL | DIV} on accept; MUL/DIV -> DONE when iteration counter reaches DATA_WIDTH; DONE -> IDLE on out_ready.
REQ-016 SHALL hold out_valid = 1 only in DONE; ALUResult stable while out_valid && !out_ready.
REQ-017 SHALL execute single-cycle ops (out_valid the cycle after accept): AND 00000, OR 00001, ADD 00010, SUB 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, EQ 01000, SLT 01001, SLTU 01010.
REQ-018 SHALL wrap ADD/SUB modulo 2^DATA_WIDTH; shifts use SrcB[$clog2(DATA_WIDTH)-1:0]; EQ/SLT/SLTU return 1 or 0 zero-extended.
REQ-019 SHALL execute MUL 10000 (low half), MULH 10001 (signed x signed, high half), MULHU 10010 (unsigned, high half) by shift-add, one bit per cycle, out_valid exactly DATA_WIDTH+1 cycles after accept.
REQ-020 SHALL execute DIV 10100, DIVU 10101, REM 10110, REMU 10111 by restoring division, one bit per cycle, out_valid exactly DATA_WIDTH+1 cycles after accept; signed ops divide magnitudes, quotient negated if signs differ, remainder takes the dividend's sign.
REQ-021 SHALL short-circuit divide-by-zero in one cycle: quotient all-ones, remainder = SrcA.
REQ-022 SHALL short-circuit signed overflow (SrcA = most-negative, SrcB = -1) in one cycle: DIV = SrcA, REM = 0.
REQ-023 SHALL return 0 in one cycle for any undefined opcode.
REQ-024 SHALL ignore in_valid while busy; no request is queued.

Reset
REQ-025 SHALL on rst_n low, immediately and asynchronously: state IDLE, out_valid 0, ALUResult 0, busy 0, counter 0, iteration registers 0.
REQ-026 SHALL abandon an in-flight MUL/DIV on reset mid-operation; no result is ever presented for it.
REQ-027 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 SHALL place the opcode enum (alu_op_t), FSM state enum and op-class helper functions in package alu_pkg.
REQ-029 SHALL implement MUL/DIV iteration in one sub-module, alu_muldiv_core (start, op, operands in; done, result out), owned by the alu_iter FSM.
REQ-030 SHALL size the iteration counter $clog2(DATA_WIDTH)+1 bits.

Verification (DATA_WIDTH = 32)
REQ-031 SHALL check ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, out_valid 1 cycle after accept; SLT 0xFFFFFFFF, 0x00000001 -> 1; SLTU same operands -> 0.
REQ-032 SHALL check MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULHU same -> 0x00000001; MUL 0x00010000 x 0x00010000 -> 0x00000000; each out_valid at cycle 33.
REQ-033 SHALL check DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14 at cycle 33.
REQ-034 SHALL check DIV 7 / 0 -> 0xFFFFFFFF, REM 7 / 0 -> 7, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, all at cycle 1.
REQ-035 SHALL check out_ready held low 5 cycles in DONE: ALUResult and out_valid stable, in_ready 0, in_valid pulses ignored.
REQ-036 SHALL check rst_n asserted at cycle 10 of a MUL: out_valid and busy 0 at once, no stale result after release, next ADD 2 + 3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and op-class helpers for the iterative ALU.
package alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_ADD   = 5'b00010,
        OP_SUB   = 5'b00011,
        OP_XOR   = 5'b00100,
        OP_SLL   = 5'b00101,
        OP_SRL   = 5'b00110,
        OP_SRA   = 5'b00111,
        OP_EQ    = 5'b01000,
        OP_SLT   = 5'b01001,
        OP_SLTU  = 5'b01010,
        OP_MUL   = 5'b10000,
        OP_MULH  = 5'b10001,
        OP_MULHU = 5'b10010,
        OP_DIV   = 5'b10100,
        OP_DIVU  = 5'b10101,
        OP_REM   = 5'b10110,
        OP_REMU  = 5'b10111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DONE,
        ST_MUL,
        ST_DIV
    } alu_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Ops whose operands are treated as two's complement magnitudes.
    function automatic logic is_signed_op(input alu_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input alu_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// One-bit-per-cycle shift-add multiplier and restoring divider on shared registers.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  alu_op_t               i_op,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic                  r_active;
    logic [CNT_W-1:0]      r_count;
    alu_op_t               r_op;
    logic                  r_neg;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_shf;
    logic [DATA_WIDTH-1:0] r_opd;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH:0]   w_div_trial;
    logic                  w_div_ok;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_shf_next;
    logic [DATA_WIDTH-1:0] w_mulh_neg;

    assign w_a_neg = is_signed_op(i_op) & i_src_a[DATA_WIDTH-1];
    assign w_b_neg = is_signed_op(i_op) & i_src_b[DATA_WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_mag = w_b_neg ? -i_src_b : i_src_b;

    // r_acc holds the product high half / partial remainder, r_shf the multiplier / dividend.
    assign w_mul_sum   = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opd} : '0);
    assign w_div_trial = {r_acc, r_shf[DATA_WIDTH-1]} - {1'b0, r_opd};
    assign w_div_ok    = ~w_div_trial[DATA_WIDTH];

    always_comb begin
        if (is_mul_op(r_op)) begin
            w_acc_next = w_mul_sum[DATA_WIDTH:1];
            w_shf_next = {w_mul_sum[0], r_shf[DATA_WIDTH-1:1]};
        end else begin
            w_acc_next = w_div_ok ? w_div_trial[DATA_WIDTH-1:0]
                                  : {r_acc[DATA_WIDTH-2:0], r_shf[DATA_WIDTH-1]};
            w_shf_next = {r_shf[DATA_WIDTH-2:0], w_div_ok};
        end
    end

    // High half of the negated product: ~hi plus the carry out of negating lo.
    assign w_mulh_neg = ~w_acc_next + DATA_WIDTH'(w_shf_next == '0);

    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:          o_result = w_shf_next;
            OP_MULHU:        o_result = w_acc_next;
            OP_MULH:         o_result = r_neg ? w_mulh_neg : w_acc_next;
            OP_DIV, OP_DIVU: o_result = r_neg ? -w_shf_next : w_shf_next;
            OP_REM, OP_REMU: o_result = r_neg ? -w_acc_next : w_acc_next;
            default:         o_result = '0;
        endcase
    end

    assign o_done = r_active && (r_count == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_op     <= OP_AND;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_shf    <= '0;
            r_opd    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= '0;
            r_op     <= i_op;
            r_neg    <= is_rem_op(i_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_acc    <= '0;
            r_shf    <= w_a_mag;
            r_opd    <= w_b_mag;
        end else if (r_active) begin
            r_acc   <= w_acc_next;
            r_shf   <= w_shf_next;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_CNT) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative MUL/DIV via alu_muldiv_core.
module alu_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    alu_state_t            r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_result;

    alu_op_t               w_op;
    logic                  w_op_known;
    logic [SH_W-1:0]       w_shamt;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_need_core;
    logic                  w_core_start;
    logic                  w_core_done;
    logic [DATA_WIDTH-1:0] w_core_result;
    logic [DATA_WIDTH-1:0] w_fast_result;

    // Opcodes with any bit set above the defined field are undefined.
    assign w_op       = alu_op_t'(Operation[ALU_OP_W-1:0]);
    assign w_op_known = ((Operation >> ALU_OP_W) == '0);
    assign w_shamt    = SrcB[SH_W-1:0];
    assign w_div_zero = (SrcB == '0);
    assign w_div_ovf  = is_signed_op(w_op) && (SrcA == MOST_NEG) && (SrcB == '1);

    assign w_need_core  = w_op_known && (is_mul_op(w_op) ||
                          (is_div_op(w_op) && !w_div_zero && !w_div_ovf));
    assign w_core_start = r_in_ready && in_valid && w_need_core;

    always_comb begin
        w_fast_result = '0;
        if (w_op_known) begin
            case (w_op)
                OP_AND:  w_fast_result = SrcA & SrcB;
                OP_OR:   w_fast_result = SrcA | SrcB;
                OP_ADD:  w_fast_result = SrcA + SrcB;
                OP_SUB:  w_fast_result = SrcA - SrcB;
                OP_XOR:  w_fast_result = SrcA ^ SrcB;
                OP_SLL:  w_fast_result = SrcA << w_shamt;
                OP_SRL:  w_fast_result = SrcA >> w_shamt;
                OP_SRA:  w_fast_result = $signed(SrcA) >>> w_shamt;
                OP_EQ:   w_fast_result = DATA_WIDTH'(SrcA == SrcB);
                OP_SLT:  w_fast_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
                OP_SLTU: w_fast_result = DATA_WIDTH'(SrcA < SrcB);
                // Only the divide short-circuits reach here: by-zero or signed overflow.
                OP_DIV, OP_DIVU: w_fast_result = w_div_zero ? '1 : SrcA;
                OP_REM, OP_REMU: w_fast_result = w_div_zero ? SrcA : '0;
                default: w_fast_result = '0;
            endcase
        end
    end

    alu_muldiv_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_core_start),
        .i_op     (w_op),
        .i_src_a  (SrcA),
        .i_src_b  (SrcB),
        .o_done   (w_core_done),
        .o_result (w_core_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_need_core) begin
                            r_state <= is_mul_op(w_op) ? ST_MUL : ST_DIV;
                        end else begin
                            r_state     <= ST_DONE;
                            r_result    <= w_fast_result;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_core_done) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_core_result;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign ALUResult = r_result;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter (DATA_WIDTH = 32) with immediate-assertion checks.
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [4:0]  Operation = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] ALUResult;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure cycles to out_valid, check result, then consume it.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        SrcA      = a;
        SrcB      = b;
        Operation = op;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        SrcA     = 32'hDEAD_BEEF;
        SrcB     = 32'h1234_5678;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " result"}, ALUResult, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int stale;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", ALUResult, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op("ADD ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        run_op("SLT", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        run_op("SLTU", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        run_op("SUB wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
        run_op("SRA", OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1);
        run_op("SLL shamt", OP_SLL, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1);
        run_op("EQ", OP_EQ, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1);
        run_op("undef op", 5'b01011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);

        run_op("MULH", OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33);
        run_op("MUL", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
        run_op("DIV neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("REM neg", OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        run_op("DIV by 0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REM by 0", OP_REM, 32'd7, 32'd0, 32'd7, 1);
        run_op("DIVU by 0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Result held in DONE while the consumer stalls; new requests are ignored.
        @(negedge clk);
        SrcA = 32'd5;
        SrcB = 32'd6;
        Operation = OP_ADD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold first valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            SrcA = 32'd100 + 32'(i);
            SrcB = 32'd1;
            Operation = OP_SUB;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("hold result %0d", i), ALUResult, 32'd11);
            check($sformatf("hold valid %0d", i), 32'(out_valid), 32'd1);
            check($sformatf("hold in_ready %0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold release valid", 32'(out_valid), 32'd0);
        check("hold release in_ready", 32'(in_ready), 32'd1);
        check("hold release busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("no queued request", 32'(out_valid), 32'd0);

        // Reset during an in-flight MUL.
        @(negedge clk);
        SrcA = 32'd1234;
        SrcB = 32'd5678;
        Operation = OP_MUL;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mul in flight busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", ALUResult, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no stale result", 32'(stale), 32'd0);
        run_op("ADD after reset", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
